// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline latches (id_ex, ex_mem,
// mem_wb).
//   DATA_W_DEF / REG_W_DEF : default datapath and register-number widths
//   REG_ZERO               : architectural register $zero (never written)
//   ex_mem_ctrl_t          : MEM/WB control bundle carried through the latches
//   ctrl_bubble()          : control bundle of a bubble (all zero)
//   ex_mem_act_t           : per-edge action of a pipeline latch
//   latch_action()         : resolves flush/stall into one action
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  localparam logic [REG_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ex_mem_ctrl_t;

  // What a pipeline latch does on a given clock edge.
  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2
  } ex_mem_act_t;

  function automatic ex_mem_ctrl_t ctrl_bubble();
    return '0;
  endfunction

  // Flush beats stall: a squashed instruction must never be held.
  function automatic ex_mem_act_t latch_action(input logic flush, input logic stall);
    if (flush) begin
      return ACT_FLUSH;
    end else if (stall) begin
      return ACT_STALL;
    end else begin
      return ACT_LOAD;
    end
  endfunction

endpackage

// File: rtl/ex_mem_latch_if.sv
// -----------------------------------------------------------------------------
// ex_mem_latch_if
// Bus between the EX stage (master) and the EX/MEM latch (slave), also carrying
// the latch's registered outputs toward the MEM stage.
// Parameters: DATA_W (data/address width), REG_W (register number width),
//             CNT_W (performance counter width).
// Modports:
//   slave  : latch view  - *_i are inputs, *_o are outputs
//   master : driver view - *_i are outputs, *_o are inputs
// Optional macro EX_MEM_FWD_EN adds id_rs_i/id_rt_i and fwd_rs_hit_o/
// fwd_rt_hit_o.
// -----------------------------------------------------------------------------
interface ex_mem_latch_if #(
  parameter int DATA_W = mips_pipe_pkg::DATA_W_DEF,
  parameter int REG_W  = mips_pipe_pkg::REG_W_DEF,
  parameter int CNT_W  = 16
) ();

  // EX-stage side
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [DATA_W-1:0] alu_result_i;
  logic [DATA_W-1:0] store_data_i;
  logic [REG_W-1:0]  wr_reg_i;
  logic [DATA_W-1:0] branch_target_i;
  logic              zero_i;
  logic              reg_write_i;
  logic              mem_read_i;
  logic              mem_write_i;
  logic              mem_to_reg_i;
  logic              branch_i;

  // MEM-stage side
  logic              valid_o;
  logic [DATA_W-1:0] alu_result_o;
  logic [DATA_W-1:0] store_data_o;
  logic [DATA_W-1:0] branch_target_o;
  logic [REG_W-1:0]  wr_reg_o;
  logic              reg_write_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic              mem_to_reg_o;
  logic              pc_src_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

`ifdef EX_MEM_FWD_EN
  logic [REG_W-1:0]  id_rs_i;
  logic [REG_W-1:0]  id_rt_i;
  logic              fwd_rs_hit_o;
  logic              fwd_rt_hit_o;
`endif

  modport slave (
    input  stall_i, flush_i, valid_i, alu_result_i, store_data_i, wr_reg_i,
           branch_target_i, zero_i, reg_write_i, mem_read_i, mem_write_i,
           mem_to_reg_i, branch_i,
    output valid_o, alu_result_o, store_data_o, branch_target_o, wr_reg_o,
           reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, pc_src_o,
           stall_cnt_o, bubble_cnt_o
`ifdef EX_MEM_FWD_EN
    ,
    input  id_rs_i, id_rt_i,
    output fwd_rs_hit_o, fwd_rt_hit_o
`endif
  );

  modport master (
    output stall_i, flush_i, valid_i, alu_result_i, store_data_i, wr_reg_i,
           branch_target_i, zero_i, reg_write_i, mem_read_i, mem_write_i,
           mem_to_reg_i, branch_i,
    input  valid_o, alu_result_o, store_data_o, branch_target_o, wr_reg_o,
           reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, pc_src_o,
           stall_cnt_o, bubble_cnt_o
`ifdef EX_MEM_FWD_EN
    ,
    output id_rs_i, id_rt_i,
    input  fwd_rs_hit_o, fwd_rt_hit_o
`endif
  );

endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at all-ones instead of wrapping. Used for pipeline
// performance-debug statistics.
// Parameter: W - counter width.
// Ports:
//   clk    : clock, counts on rising edge
//   rst_n  : asynchronous active-low clear
//   i_inc  : count this edge
//   o_cnt  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_full;

  assign w_full = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ex_mem_latch.sv
// -----------------------------------------------------------------------------
// ex_mem_latch
// EX/MEM pipeline register of the 5-stage MIPS pipeline. Captures the ALU
// result, store data, destination register (from the rt/rd MUX), branch
// target and MEM/WB control bits, with stall hold, flush-to-bubble and a
// registered branch decision (pc_src). Two saturating counters report stall
// and bubble edges.
// Parameters: DATA_W (32), REG_W (5), CNT_W (16).
// Ports:
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset, clears all outputs and counters
//   bus   : ex_mem_latch_if.slave - EX-side inputs (*_i), MEM-side outputs
//           (*_o) and the stall/bubble counters
// Edge priority: reset > flush > stall > load.
// Optional macro EX_MEM_FWD_EN: adds combinational forwarding-hit outputs
// fwd_rs_hit_o / fwd_rt_hit_o comparing the latched destination with the
// ID-stage source registers id_rs_i / id_rt_i.
// -----------------------------------------------------------------------------
module ex_mem_latch
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_mem_latch_if.slave  bus
);

  ex_mem_act_t       w_act;
  logic              w_wr_nonzero;
  ex_mem_ctrl_t      w_ctrl_in;

  // In the registered bundle the branch field holds the resolved decision
  // (branch & zero & valid), i.e. pc_src, not the raw branch bit.
  ex_mem_ctrl_t      r_ctrl;
  ex_mem_ctrl_t      w_ctrl_next;
  logic              r_valid;
  logic              w_valid_next;
  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] w_alu_result_next;
  logic [DATA_W-1:0] r_store_data;
  logic [DATA_W-1:0] w_store_data_next;
  logic [DATA_W-1:0] r_branch_target;
  logic [DATA_W-1:0] w_branch_target_next;
  logic [REG_W-1:0]  r_wr_reg;
  logic [REG_W-1:0]  w_wr_reg_next;

  logic              w_stall_inc;
  logic              w_bubble_inc;
  logic [CNT_W-1:0]  w_stall_cnt;
  logic [CNT_W-1:0]  w_bubble_cnt;

  assign w_act        = latch_action(bus.flush_i, bus.stall_i);
  assign w_wr_nonzero = (bus.wr_reg_i != REG_W'(REG_ZERO));

  // Incoming control bundle, qualified by valid so a non-instruction can never
  // write state downstream. A write to $zero is dropped here so MEM/WB and the
  // forwarding logic never see it as a producer.
  always_comb begin
    w_ctrl_in            = ctrl_bubble();
    w_ctrl_in.reg_write  = bus.reg_write_i  & bus.valid_i & w_wr_nonzero;
    w_ctrl_in.mem_read   = bus.mem_read_i   & bus.valid_i;
    w_ctrl_in.mem_write  = bus.mem_write_i  & bus.valid_i;
    w_ctrl_in.mem_to_reg = bus.mem_to_reg_i & bus.valid_i;
    w_ctrl_in.branch     = bus.branch_i     & bus.zero_i  & bus.valid_i;
  end

  always_comb begin
    w_valid_next         = r_valid;
    w_ctrl_next          = r_ctrl;
    w_alu_result_next    = r_alu_result;
    w_store_data_next    = r_store_data;
    w_branch_target_next = r_branch_target;
    w_wr_reg_next        = r_wr_reg;
    w_stall_inc          = 1'b0;
    w_bubble_inc         = 1'b0;

    case (w_act)
      ACT_FLUSH: begin
        // Data fields are zeroed as well so bubbles look identical in waves.
        w_valid_next         = 1'b0;
        w_ctrl_next          = ctrl_bubble();
        w_alu_result_next    = '0;
        w_store_data_next    = '0;
        w_branch_target_next = '0;
        w_wr_reg_next        = '0;
        w_bubble_inc         = 1'b1;
      end
      ACT_STALL: begin
        w_stall_inc = 1'b1;
      end
      default: begin
        w_valid_next         = bus.valid_i;
        w_ctrl_next          = w_ctrl_in;
        w_alu_result_next    = bus.alu_result_i;
        w_store_data_next    = bus.store_data_i;
        w_branch_target_next = bus.branch_target_i;
        w_wr_reg_next        = bus.wr_reg_i;
        w_bubble_inc         = ~bus.valid_i;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid         <= 1'b0;
      r_ctrl          <= ctrl_bubble();
      r_alu_result    <= '0;
      r_store_data    <= '0;
      r_branch_target <= '0;
      r_wr_reg        <= '0;
    end else begin
      r_valid         <= w_valid_next;
      r_ctrl          <= w_ctrl_next;
      r_alu_result    <= w_alu_result_next;
      r_store_data    <= w_store_data_next;
      r_branch_target <= w_branch_target_next;
      r_wr_reg        <= w_wr_reg_next;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_stall_inc),
    .o_cnt (w_stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_bubble_inc),
    .o_cnt (w_bubble_cnt)
  );

  assign bus.valid_o         = r_valid;
  assign bus.alu_result_o    = r_alu_result;
  assign bus.store_data_o    = r_store_data;
  assign bus.branch_target_o = r_branch_target;
  assign bus.wr_reg_o        = r_wr_reg;
  assign bus.reg_write_o     = r_ctrl.reg_write;
  assign bus.mem_read_o      = r_ctrl.mem_read;
  assign bus.mem_write_o     = r_ctrl.mem_write;
  assign bus.mem_to_reg_o    = r_ctrl.mem_to_reg;
  assign bus.pc_src_o        = r_ctrl.branch;
  assign bus.stall_cnt_o     = w_stall_cnt;
  assign bus.bubble_cnt_o    = w_bubble_cnt;

`ifdef EX_MEM_FWD_EN
  logic w_fwd_src_ok;

  // A latched instruction is a forwarding source only if it really writes a
  // non-zero register.
  assign w_fwd_src_ok     = r_valid & r_ctrl.reg_write & (r_wr_reg != REG_W'(REG_ZERO));
  assign bus.fwd_rs_hit_o = w_fwd_src_ok & (r_wr_reg == bus.id_rs_i);
  assign bus.fwd_rt_hit_o = w_fwd_src_ok & (r_wr_reg == bus.id_rt_i);
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_latch
// Self-checking bench for ex_mem_latch: a directed vector table, hand-written
// reset / saturation / forwarding sequences, and randomized traffic checked
// against a behavioural model. A second instance with 4-bit counters shares
// the stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_ex_mem_latch;
  import mips_pipe_pkg::*;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ex_mem_latch_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW))  m_if ();
  ex_mem_latch_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CWS)) s_if ();

  ex_mem_latch #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_if)
  );

  ex_mem_latch #(.DATA_W(DW), .REG_W(RW), .CNT_W(CWS)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if)
  );

  assign s_if.stall_i         = m_if.stall_i;
  assign s_if.flush_i         = m_if.flush_i;
  assign s_if.valid_i         = m_if.valid_i;
  assign s_if.alu_result_i    = m_if.alu_result_i;
  assign s_if.store_data_i    = m_if.store_data_i;
  assign s_if.wr_reg_i        = m_if.wr_reg_i;
  assign s_if.branch_target_i = m_if.branch_target_i;
  assign s_if.zero_i          = m_if.zero_i;
  assign s_if.reg_write_i     = m_if.reg_write_i;
  assign s_if.mem_read_i      = m_if.mem_read_i;
  assign s_if.mem_write_i     = m_if.mem_write_i;
  assign s_if.mem_to_reg_i    = m_if.mem_to_reg_i;
  assign s_if.branch_i        = m_if.branch_i;
`ifdef EX_MEM_FWD_EN
  assign s_if.id_rs_i         = m_if.id_rs_i;
  assign s_if.id_rt_i         = m_if.id_rt_i;
`endif

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] tgt;
    logic [4:0]  wr;
    logic        zero;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        br;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] tgt;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        pc;
  } obs_t;

  typedef struct {
    string name;
    stim_t s;
    obs_t  e;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  obs_t mdl;
  int   n_stall;
  int   n_bubble;

  function automatic stim_t mk_stim(logic stall, logic flush, logic valid,
                                    logic [31:0] alu, logic [31:0] sd, logic [31:0] tgt,
                                    logic [4:0] wr, logic zero, logic rw, logic mr,
                                    logic mw, logic m2r, logic br);
    stim_t s;
    s.stall = stall; s.flush = flush; s.valid = valid;
    s.alu = alu; s.sd = sd; s.tgt = tgt; s.wr = wr; s.zero = zero;
    s.rw = rw; s.mr = mr; s.mw = mw; s.m2r = m2r; s.br = br;
    return s;
  endfunction

  function automatic obs_t mk_obs(logic valid, logic [31:0] alu, logic [31:0] sd,
                                  logic [31:0] tgt, logic [4:0] wr, logic rw,
                                  logic mr, logic mw, logic m2r, logic pc);
    obs_t o;
    o.valid = valid; o.alu = alu; o.sd = sd; o.tgt = tgt; o.wr = wr;
    o.rw = rw; o.mr = mr; o.mw = mw; o.m2r = m2r; o.pc = pc;
    return o;
  endfunction

  function automatic obs_t sample_obs();
    obs_t o;
    o.valid = m_if.valid_o;
    o.alu   = m_if.alu_result_o;
    o.sd    = m_if.store_data_o;
    o.tgt   = m_if.branch_target_o;
    o.wr    = m_if.wr_reg_o;
    o.rw    = m_if.reg_write_o;
    o.mr    = m_if.mem_read_o;
    o.mw    = m_if.mem_write_o;
    o.m2r   = m_if.mem_to_reg_o;
    o.pc    = m_if.pc_src_o;
    return o;
  endfunction

  function automatic logic [31:0] sat(int n, int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? 32'(mx) : 32'(n);
  endfunction

  // Behavioural model: what the MEM stage should see after each edge.
  function automatic void model_reset();
    mdl      = '0;
    n_stall  = 0;
    n_bubble = 0;
  endfunction

  function automatic void model_step(stim_t s);
    if (s.flush) begin
      mdl = '0;
      n_bubble++;
    end else if (s.stall) begin
      n_stall++;
    end else begin
      mdl.valid = s.valid;
      mdl.alu   = s.alu;
      mdl.sd    = s.sd;
      mdl.tgt   = s.tgt;
      mdl.wr    = s.wr;
      mdl.rw    = s.valid && s.rw && (s.wr != 5'd0);
      mdl.mr    = s.valid && s.mr;
      mdl.mw    = s.valid && s.mw;
      mdl.m2r   = s.valid && s.m2r;
      mdl.pc    = s.valid && s.br && s.zero;
      if (!s.valid) n_bubble++;
    end
  endfunction

  task automatic check32(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%h expected=0x%h", name, got, exp);
    end
  endtask

  task automatic check_obs(string name, obs_t exp);
    obs_t got;
    got = sample_obs();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got valid=%0b alu=%h sd=%h tgt=%h wr=%h rw=%0b mr=%0b mw=%0b m2r=%0b pc=%0b expected valid=%0b alu=%h sd=%h tgt=%h wr=%h rw=%0b mr=%0b mw=%0b m2r=%0b pc=%0b",
               name, got.valid, got.alu, got.sd, got.tgt, got.wr, got.rw, got.mr, got.mw, got.m2r, got.pc,
               exp.valid, exp.alu, exp.sd, exp.tgt, exp.wr, exp.rw, exp.mr, exp.mw, exp.m2r, exp.pc);
    end
  endtask

  task automatic check_counters(string tag);
    check32({tag, " stall_cnt"},      32'(m_if.stall_cnt_o),  sat(n_stall,  CW));
    check32({tag, " bubble_cnt"},     32'(m_if.bubble_cnt_o), sat(n_bubble, CW));
    check32({tag, " stall_cnt_w4"},   32'(s_if.stall_cnt_o),  sat(n_stall,  CWS));
    check32({tag, " bubble_cnt_w4"},  32'(s_if.bubble_cnt_o), sat(n_bubble, CWS));
  endtask

`ifdef EX_MEM_FWD_EN
  task automatic check_fwd(string tag);
    logic exp_rs;
    logic exp_rt;
    exp_rs = mdl.valid && mdl.rw && (mdl.wr != 5'd0) && (mdl.wr == m_if.id_rs_i);
    exp_rt = mdl.valid && mdl.rw && (mdl.wr != 5'd0) && (mdl.wr == m_if.id_rt_i);
    check32({tag, " fwd_rs_hit"}, 32'(m_if.fwd_rs_hit_o), 32'(exp_rs));
    check32({tag, " fwd_rt_hit"}, 32'(m_if.fwd_rt_hit_o), 32'(exp_rt));
  endtask
`endif

  task automatic drive(stim_t s);
    // Upstream must never issue a load and a store together.
    assert (!(s.mr && s.mw)) else $error("illegal stimulus: mem_read and mem_write both set");
    m_if.stall_i         = s.stall;
    m_if.flush_i         = s.flush;
    m_if.valid_i         = s.valid;
    m_if.alu_result_i    = s.alu;
    m_if.store_data_i    = s.sd;
    m_if.branch_target_i = s.tgt;
    m_if.wr_reg_i        = s.wr;
    m_if.zero_i          = s.zero;
    m_if.reg_write_i     = s.rw;
    m_if.mem_read_i      = s.mr;
    m_if.mem_write_i     = s.mw;
    m_if.mem_to_reg_i    = s.m2r;
    m_if.branch_i        = s.br;
  endtask

  // One transaction: drive, clock, sample 1 time unit after the edge.
  task automatic step(string tag, stim_t s);
    drive(s);
    @(posedge clk);
    #1;
    model_step(s);
    $display("txn %-14s stall=%0b flush=%0b valid=%0b wr=%0d -> valid_o=%0b wr_o=%0d rw_o=%0b pc_o=%0b scnt=%0d bcnt=%0d",
             tag, s.stall, s.flush, s.valid, s.wr, m_if.valid_o, m_if.wr_reg_o,
             m_if.reg_write_o, m_if.pc_src_o, m_if.stall_cnt_o, m_if.bubble_cnt_o);
    check_counters(tag);
  endtask

  vec_t  vecs[10];
  stim_t rs;
  stim_t stall_s;

  initial begin
    vecs[0] = '{"reset_load",
      mk_stim(0,0,1, 32'h0000_00A5, 32'h0, 32'h0, 5'b01010, 0,1,0,0,0,0),
      mk_obs (1,     32'h0000_00A5, 32'h0, 32'h0, 5'b01010, 1,0,0,0,0)};
    vecs[1] = '{"load_10101",
      mk_stim(0,0,1, 32'h1234_5678, 32'hCAFE_F00D, 32'h0, 5'b10101, 0,1,1,0,1,0),
      mk_obs (1,     32'h1234_5678, 32'hCAFE_F00D, 32'h0, 5'b10101, 1,1,0,1,0)};
    for (int i = 2; i <= 4; i++) begin
      vecs[i] = '{$sformatf("stall_%0d", i - 1),
        mk_stim(1,0,1, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 5'b11111, 1,1,0,1,0,1),
        mk_obs (1,     32'h1234_5678, 32'hCAFE_F00D, 32'h0, 5'b10101, 1,1,0,1,0)};
    end
    vecs[5] = '{"flush_stall",
      mk_stim(1,1,1, 32'hDEAD_BEEF, 32'h3333, 32'h4444, 5'b11111, 1,1,1,0,1,1),
      mk_obs (0,     32'h0, 32'h0, 32'h0, 5'b00000, 0,0,0,0,0)};
    vecs[6] = '{"reg_zero",
      mk_stim(0,0,1, 32'h7, 32'h8, 32'h0, 5'b00000, 0,1,0,0,0,0),
      mk_obs (1,     32'h7, 32'h8, 32'h0, 5'b00000, 0,0,0,0,0)};
    vecs[7] = '{"branch_taken",
      mk_stim(0,0,1, 32'h0, 32'h0, 32'h0040_0010, 5'b00000, 1,0,0,0,0,1),
      mk_obs (1,     32'h0, 32'h0, 32'h0040_0010, 5'b00000, 0,0,0,0,1)};
    vecs[8] = '{"branch_invalid",
      mk_stim(0,0,0, 32'h55, 32'h66, 32'h0040_0020, 5'b00011, 1,1,0,1,0,1),
      mk_obs (0,     32'h55, 32'h66, 32'h0040_0020, 5'b00011, 0,0,0,0,0)};
    vecs[9] = '{"branch_notzero",
      mk_stim(0,0,1, 32'h99, 32'hAA, 32'h0040_0030, 5'b01001, 0,1,0,1,0,1),
      mk_obs (1,     32'h99, 32'hAA, 32'h0040_0030, 5'b01001, 1,0,1,0,0)};

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    drive('0);
`ifdef EX_MEM_FWD_EN
    m_if.id_rs_i = '0;
    m_if.id_rt_i = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset_state", '0);
    check_counters("reset_state");
    rst_n = 1'b1;

    // ---------------- directed table ----------------
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].name, vecs[i].s);
      check_obs(vecs[i].name, vecs[i].e);
      if (i == 4) check32("stall_cnt_after_3", 32'(m_if.stall_cnt_o), 32'd3);
      if (i == 5) check32("bubble_after_flush", 32'(m_if.bubble_cnt_o), 32'd1);
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_obs("async_reset", '0);
    check_counters("async_reset");
    @(posedge clk);
    #1;
    check_obs("reset_held", '0);
    #2;
    rst_n = 1'b1;
    #1;
    check_obs("reset_release", '0);
    step("load_after_rst", vecs[0].s);
    check_obs("load_after_rst", vecs[0].e);

    // ---------------- counter saturation (4-bit instance) ----------------
    stall_s = mk_stim(1,0,1, 32'h1, 32'h2, 32'h3, 5'b11111, 0,1,0,0,0,0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat_stall_%0d", i), stall_s);
      check_obs("sat_stall_hold", vecs[0].e);
    end
    check32("sat_stall_w4_pinned", 32'(s_if.stall_cnt_o), 32'hF);
    check32("sat_stall_w16_20",    32'(m_if.stall_cnt_o), 32'd20);

`ifdef EX_MEM_FWD_EN
    // ---------------- forwarding hits ----------------
    step("fwd_load_5", mk_stim(0,0,1, 32'h0, 32'h0, 32'h0, 5'b00101, 0,1,0,0,0,0));
    m_if.id_rs_i = 5'b00101;
    m_if.id_rt_i = 5'b00110;
    #1;
    check32("fwd_rs_hit_5", 32'(m_if.fwd_rs_hit_o), 32'd1);
    check32("fwd_rt_miss_6", 32'(m_if.fwd_rt_hit_o), 32'd0);
    step("fwd_load_0", mk_stim(0,0,1, 32'h0, 32'h0, 32'h0, 5'b00000, 0,1,0,0,0,0));
    m_if.id_rs_i = 5'b00000;
    #1;
    check32("fwd_rs_zero", 32'(m_if.fwd_rs_hit_o), 32'd0);
`endif

    // ---------------- randomized traffic vs model ----------------
    for (int n = 0; n < 400; n++) begin
      rs.stall = ($urandom_range(0, 3) == 0);
      rs.flush = ($urandom_range(0, 7) == 0);
      rs.valid = ($urandom_range(0, 3) != 0);
      rs.alu   = $urandom;
      rs.sd    = $urandom;
      rs.tgt   = $urandom;
      rs.wr    = 5'($urandom_range(0, 7));
      rs.zero  = 1'($urandom_range(0, 1));
      rs.rw    = 1'($urandom_range(0, 1));
      rs.mr    = 1'($urandom_range(0, 1));
      rs.mw    = rs.mr ? 1'b0 : 1'($urandom_range(0, 1));
      rs.m2r   = 1'($urandom_range(0, 1));
      rs.br    = 1'($urandom_range(0, 1));
`ifdef EX_MEM_FWD_EN
      m_if.id_rs_i = 5'($urandom_range(0, 7));
      m_if.id_rt_i = 5'($urandom_range(0, 7));
`endif
      step($sformatf("rand_%0d", n), rs);
      check_obs($sformatf("rand_%0d", n), mdl);
`ifdef EX_MEM_FWD_EN
      check_fwd($sformatf("rand_%0d", n));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
- EX/MEM pipeline register of the 5-stage MIPS pipeline.
- Sits directly downstream of the EX-stage 5-bit destination-register MUX, which selects rt or rd; that MUX output drives wr_reg_i.
- Captures the ALU result, store data, destination register and MEM/WB control bits, with stall hold, flush-to-bubble and a registered branch decision.
- Provides saturating stall and bubble counters for pipeline performance debug.

Parameters:
- DATA_W, 32, width of ALU result, store data and branch target.
- REG_W, 5, register-number width; must match the destination MUX width.
- CNT_W, 16, width of the stall and bubble counters.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold all state this cycle.
- flush_i  input  1  replace the captured instruction with a bubble.
- valid_i  input  1  EX stage holds a real instruction.
- alu_result_i  input  DATA_W  ALU output.
- store_data_i  input  DATA_W  rt value for sw.
- wr_reg_i  input  REG_W  destination register from the rt/rd MUX.
- branch_target_i  input  DATA_W  computed branch address.
- zero_i  input  1  ALU zero flag.
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i  input  1 each  control bits.
- valid_o  output  1  MEM stage holds a real instruction.
- alu_result_o, store_data_o, branch_target_o  output  DATA_W  registered copies.
- wr_reg_o  output  REG_W  registered destination register.
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  output  1 each  registered control bits, gated by valid.
- pc_src_o  output  1  branch taken: registered branch & zero & valid.
- stall_cnt_o, bubble_cnt_o  output  CNT_W  saturating counters.

Behaviour:
- Reset (rst_n=0, asynchronous): every output, including both counters, goes to 0. Reset released mid-operation resumes from the bubble state.
- Latency: exactly 1 cycle from inputs to outputs. No combinational path from input to output, except under the optional feature.
- Per-edge priority: reset > flush > stall > load.
- Flush:
  - valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o and pc_src_o become 0.
  - Data and address outputs become 0, for deterministic waveforms.
  - flush_i together with stall_i: the flush wins; the stall counter does not increment.
- Stall (no flush): all outputs hold their previous values. stall_cnt increments.
- Load:
  - All fields are captured.
  - valid_o <= valid_i.
  - The control outputs and pc_src_o are ANDed with valid_i before capture.
- Register zero rule: if wr_reg_i == 0, reg_write_o is captured as 0. wr_reg_o still holds 0.
- mem_read_i and mem_write_i both 1 is illegal upstream. The latch captures both unchanged; the bench flags it with an assertion.
- bubble_cnt increments on every edge where the new valid_o is 0 because of a flush or a load with valid_i=0. It does not increment during a stall.
- Both counters saturate at all-ones and never wrap. They are cleared only by reset.
- Any X on an input is captured as-is; no X-scrubbing.

Optional Feature:
- Macro: EX_MEM_FWD_EN.
- When defined:
  - Extra inputs: id_rs_i and id_rt_i, REG_W each.
  - Extra outputs: fwd_rs_hit_o and fwd_rt_hit_o, 1 bit each.
  - fwd_rs_hit_o = valid_o & reg_write_o & (wr_reg_o != 0) & (wr_reg_o == id_rs_i). fwd_rt_hit_o is the same, using id_rt_i.
  - These outputs are combinational from registered state and the ID inputs.
- When undefined: the ports and logic are absent, and the block is otherwise identical.

Decomposition:
- Package mips_pipe_pkg holds:
  - DATA_W_DEF and REG_W_DEF.
  - REG_ZERO constant.
  - Packed typedef ex_mem_ctrl_t (reg_write, mem_read, mem_write, mem_to_reg, branch), shared with the id_ex and mem_wb latches.
  - Function ctrl_bubble() returning an all-zero ex_mem_ctrl_t.
- One sub-module: sat_counter, parameterised by width, with inc and async active-low clear. It is instantiated twice, for stall and bubble.

Test Plan:
- Reset then load: assert rst_n low mid-cycle with outputs nonzero -> all outputs 0 immediately. Then load alu=0x0000_00A5, wr_reg=5'b01010, reg_write=1, valid=1 -> next edge: valid_o=1, wr_reg_o=01010, reg_write_o=1.
- Stall hold: load wr_reg=5'b10101, then stall_i=1 for 3 cycles with wr_reg_i=5'b11111 -> wr_reg_o stays 10101 throughout, and stall_cnt_o=3.
- Flush priority: stall_i=1 and flush_i=1 together with valid_i=1 -> valid_o=0, all controls 0, stall_cnt unchanged, bubble_cnt +1.
- Register-zero suppression: wr_reg_i=0, reg_write_i=1, valid_i=1 -> reg_write_o=0, valid_o=1.
- Branch: branch=1, zero=1, target=0x0040_0010, valid=1 -> pc_src_o=1 and branch_target_o=0x0040_0010. With valid=0 -> pc_src_o=0.
- Saturation, with CNT_W overridden to 4: hold stall_i=1 for 20 cycles -> stall_cnt_o stops at 4'hF.
- With EX_MEM_FWD_EN: wr_reg_o=5'b00101 and id_rs_i=5'b00101 -> fwd_rs_hit_o=1. With wr_reg_o=0 -> fwd_rs_hit_o=0.
